timer_status: RTL and testbench
===============================

// Module: timer_status
// PURPOSE
//  Downstream of the 8-bit timer counter. Consumes the counter value and its one-pclk-delayed copy.
//  Detects overflow (up-count FF->00) and underflow (down-count 00->FF).
//  Holds sticky flags in status register TSR; software clears them write-0-to-clear.
//  Drives the timer interrupt toward the APB register block.
// PARAMETERS
//  CNT_W     8      counter width; all compare constants derive from it
//  TSR_W     8      status register width; unused bits read 0
// PORTS
//  pclk          in   1      system clock; all logic on posedge
//  preset_n      in   1      reset, asynchronous, active-high (asserted when 1)
//  counter       in   CNT_W  current counter value
//  last_counter  in   CNT_W  counter value delayed one pclk
//  tcr           in   8      control reg: [7]=load, [4]=enable, [3]=down(1)/up(0)
//  tsr_wr_en     in   1      one-cycle write strobe to TSR
//  tsr_wdata     in   TSR_W  write data; bit=0 clears flag, bit=1 no effect
//  tsr           out  TSR_W  status: [0]=OVF, [1]=UDF, others 0
//  ovf_pulse     out  1      1-cycle registered pulse per overflow event
//  udf_pulse     out  1      1-cycle registered pulse per underflow event
//  tmr_irq       out  1      interrupt (macro-dependent, see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - tsr, ovf_pulse, udf_pulse, tmr_irq, and all internal regs = 0.
//   - Reset is immediate on assertion; any pending event is lost.
//  Qualifier pipeline:
//   - Register en_d=tcr[4], dn_d=tcr[3], ld_d=tcr[7] each pclk, aligning controls with last_counter.
//  Event detect (combinational, same cycle):
//   - ovf_det = en_d & ~dn_d & ~ld_d & last_counter=={CNT_W{1}} & counter==0
//   - udf_det = en_d &  dn_d & ~ld_d & last_counter==0 & counter=={CNT_W{1}}
//   - ld_d suppresses false flags when a TDR load jumps FF->00 or 00->FF.
//   - Counter holding at 00 or FF does not re-fire; last_counter equals counter after one cycle.
//  Latency:
//   - Detect cycle N -> ovf_pulse/udf_pulse and tsr bit high at posedge N+1.
//   - Pulse lasts exactly 1 cycle; tsr bit is sticky.
//  TSR update, per bit i, next:
//   - set_i ? 1 : (tsr_wr_en & ~tsr_wdata[i]) ? 0 : tsr[i]
//   - Simultaneous set and clear on the same bit: set wins, flag stays 1.
//   - Writing 1 never sets a flag; bits [TSR_W-1:2] always read 0 and are not writable.
//  State machine: none; purely registered flag logic.
//  Mid-operation:
//   - tcr[4] dropped: en_d falls next cycle; no new events; flags retained.
//   - Direction change: dn_d is registered, so a FF<->00 step is classified by the direction at the time of the step.
// CONFIGURATION
//  Macro TIMER_STATUS_IRQ_EN
//   - Defined: adds input irq_mask[1:0] ([0]=OVF, [1]=UDF).
//     tmr_irq = registered |(tsr[1:0] & irq_mask), asserting 1 cycle after the flag.
//     Level-held until the flag is cleared or masked.
//   - Undefined: no irq_mask port; tmr_irq tied 0. Flags and pulses are unchanged.
// STRUCTURE
//  Shared package timer_pkg:
//   - TCR bit indices: LOAD=7, EN=4, DN=3
//   - TSR bit indices: OVF=0, UDF=1
//   - CNT_MAX/CNT_MIN constants
//  Sub-module timer_edge_det: 1-bit flag cell (set/clear/set-priority), instantiated per flag.
//  Everything else stays in the top module.
// TESTING
//  1 up count, tcr=8'h10, counter 8'hFE->FF->00
//    -> ovf_pulse=1 for 1 cycle; tsr=8'h01; udf_pulse=0
//  2 down count, tcr=8'h18, counter 8'h01->00->FF
//    -> udf_pulse=1 for 1 cycle; tsr=8'h02
//  3 load TDR=8'h00 with last_counter=8'hFF (tcr=8'h90 then 8'h10)
//    -> no pulse; tsr unchanged
//  4 tsr=8'h03, write tsr_wdata=8'hFE
//    -> tsr=8'h02 next cycle; write 8'hFF -> no change
//  5 overflow detect in the same cycle as clear write of 8'hFE
//    -> tsr[0] stays 1 (set wins)
//  6 assert preset_n=1 mid-count with tsr=8'h03 and pulse high
//    -> all outputs 0 asynchronously
//    -> with TIMER_STATUS_IRQ_EN, irq_mask=2'b01, overflow: tmr_irq=1 until tsr[0] is cleared

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: control/status bit positions and counter limits.
package timer_pkg;

  localparam int TCR_LOAD = 7;
  localparam int TCR_EN   = 4;
  localparam int TCR_DN   = 3;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [7:0] CNT_MIN = 8'h00;

  typedef struct packed {
    logic ld;
    logic en;
    logic dn;
  } tcr_q_t;

endpackage

// File: rtl/timer_edge_det.sv
// Sticky 1-bit status flag: set has priority over write-0-to-clear.
module timer_edge_det (
  input  logic pclk,
  input  logic preset_n,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (set_i)
      flag_d = 1'b1;
    else if (clr_i)
      flag_d = 1'b0;
  end

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n)
      flag_q <= 1'b0;
    else
      flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/timer_status.sv
// Timer overflow/underflow detect, sticky TSR flags and interrupt.
// Optional irq_mask input and masked interrupt under TIMER_STATUS_IRQ_EN.
module timer_status
  import timer_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TSR_W = 8
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [CNT_W-1:0] counter,
  input  logic [CNT_W-1:0] last_counter,
  input  logic [7:0]       tcr,
  input  logic             tsr_wr_en,
  input  logic [TSR_W-1:0] tsr_wdata,
`ifdef TIMER_STATUS_IRQ_EN
  input  logic [1:0]       irq_mask,
`endif
  output logic [TSR_W-1:0] tsr,
  output logic             ovf_pulse,
  output logic             udf_pulse,
  output logic             tmr_irq
);

  localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MINV = '0;

  tcr_q_t qual_q;
  logic   ovf_det, udf_det;
  logic   ovf_q, udf_q;
  logic   ovf_flag, udf_flag;
  logic   ovf_clr, udf_clr;

  // Controls are delayed one cycle so they line up with last_counter.
  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      qual_q <= '0;
    end else begin
      qual_q.ld <= tcr[TCR_LOAD];
      qual_q.en <= tcr[TCR_EN];
      qual_q.dn <= tcr[TCR_DN];
    end
  end

  assign ovf_det = qual_q.en & ~qual_q.dn & ~qual_q.ld
                 & (last_counter == MAXV)
                 & (counter == MINV);
  assign udf_det = qual_q.en & qual_q.dn & ~qual_q.ld
                 & (last_counter == MINV)
                 & (counter == MAXV);

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_det;
      udf_q <= udf_det;
    end
  end

  assign ovf_clr = tsr_wr_en & ~tsr_wdata[TSR_OVF];
  assign udf_clr = tsr_wr_en & ~tsr_wdata[TSR_UDF];

  timer_edge_det u_ovf (
    .pclk     (pclk),
    .preset_n (preset_n),
    .set_i    (ovf_det),
    .clr_i    (ovf_clr),
    .flag_o   (ovf_flag)
  );

  timer_edge_det u_udf (
    .pclk     (pclk),
    .preset_n (preset_n),
    .set_i    (udf_det),
    .clr_i    (udf_clr),
    .flag_o   (udf_flag)
  );

  assign tsr       = {{(TSR_W-2){1'b0}}, udf_flag, ovf_flag};
  assign ovf_pulse = ovf_q;
  assign udf_pulse = udf_q;

`ifdef TIMER_STATUS_IRQ_EN
  logic irq_q;

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n)
      irq_q <= 1'b0;
    else
      irq_q <= |({udf_flag, ovf_flag} & irq_mask);
  end

  assign tmr_irq = irq_q;
`else
  assign tmr_irq = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{tcr[6:5], tcr[2:0], tsr_wdata[TSR_W-1:2]};

endmodule

// File: tb/tb_timer_status.sv
// Randomized and directed bench for timer_status against a behavioural model.
module tb_timer_status;

`ifdef TIMER_STATUS_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       pclk;
  logic       preset_n;
  logic [7:0] counter;
  logic [7:0] last_counter;
  logic [7:0] tcr;
  logic       tsr_wr_en;
  logic [7:0] tsr_wdata;
  logic [1:0] irq_mask;
  logic [7:0] tsr;
  logic       ovf_pulse;
  logic       udf_pulse;
  logic       tmr_irq;

  int compares = 0;
  int fails    = 0;

  // Model state: what the timer did last cycle and the flags it expects.
  logic [7:0] m_cnt;
  logic [7:0] m_tcr;
  logic [1:0] exp_tsr;
  logic       exp_ovf;
  logic       exp_udf;
  logic       exp_irq;

  timer_status dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .counter      (counter),
    .last_counter (last_counter),
    .tcr          (tcr),
    .tsr_wr_en    (tsr_wr_en),
    .tsr_wdata    (tsr_wdata),
`ifdef TIMER_STATUS_IRQ_EN
    .irq_mask     (irq_mask),
`endif
    .tsr          (tsr),
    .ovf_pulse    (ovf_pulse),
    .udf_pulse    (udf_pulse),
    .tmr_irq      (tmr_irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [10:0] got();
    return {tsr, ovf_pulse, udf_pulse, tmr_irq};
  endfunction

  function automatic logic [10:0] want();
    return {6'b0, exp_tsr, exp_ovf, exp_udf, exp_irq};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic [7:0] c, input logic [7:0] t,
                     input logic w, input logic [7:0] wd);
    logic o, u;
    logic [1:0] clr;
    last_counter = m_cnt;
    counter      = c;
    tcr          = t;
    tsr_wr_en    = w;
    tsr_wdata    = wd;
    o = m_tcr[4] && !m_tcr[3] && !m_tcr[7] && m_cnt == 8'hFF && c == 8'h00;
    u = m_tcr[4] &&  m_tcr[3] && !m_tcr[7] && m_cnt == 8'h00 && c == 8'hFF;
    exp_irq = IRQ_ON && |(exp_tsr & irq_mask);
    clr = w ? ~wd[1:0] : 2'b00;
    exp_tsr = {u, o} | (exp_tsr & ~clr);
    exp_ovf = o;
    exp_udf = u;
    m_cnt = c;
    m_tcr = t;
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    exp_tsr = 2'b00;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_irq = 1'b0;
    m_tcr   = 8'h00;
  endtask

  task automatic test_reset();
    preset_n     = 1'b1;
    counter      = 8'h00;
    last_counter = 8'h00;
    tcr          = 8'h00;
    tsr_wr_en    = 1'b0;
    tsr_wdata    = 8'hFF;
    irq_mask     = 2'b00;
    m_cnt        = 8'h00;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    compares++;
    if (got() !== want()) begin
      fails++;
      $display("FAIL reset got=%h want=%h", got(), want());
    end
    @(negedge pclk);
    preset_n = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_up_ovf();
    logic [7:0] seq [5];
    seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    foreach (seq[i]) begin
      cyc(seq[i], 8'h10, 1'b0, 8'hFF);
      compares++;
      if (got() !== want()) begin
        fails++;
        $display("FAIL up_ovf step%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_down_udf();
    logic [7:0] seq [5];
    cyc(8'h00, 8'h10, 1'b1, 8'h00);
    seq = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    foreach (seq[i]) begin
      cyc(seq[i], 8'h18, 1'b0, 8'hFF);
      compares++;
      if (got() !== want()) begin
        fails++;
        $display("FAIL down_udf step%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_load_suppress();
    cyc(8'hFF, 8'h90, 1'b0, 8'hFF);
    cyc(8'h00, 8'h10, 1'b0, 8'hFF);
    compares++;
    if (got() !== want() || ovf_pulse !== 1'b0) begin
      fails++;
      $display("FAIL load_suppress got=%h want=%h", got(), want());
    end
    cyc(8'h00, 8'h10, 1'b0, 8'hFF);
    cyc(8'h00, 8'h10, 1'b0, 8'hFF);
    compares++;
    if (got() !== want()) begin
      fails++;
      $display("FAIL hold_zero got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_w0c();
    cyc(8'hFF, 8'h10, 1'b0, 8'hFF);
    cyc(8'h00, 8'h18, 1'b0, 8'hFF);
    cyc(8'hFF, 8'h18, 1'b0, 8'hFF);
    compares++;
    if (tsr !== 8'h03) begin
      fails++;
      $display("FAIL w0c_setup got=%h want=03", tsr);
    end
    cyc(8'hFF, 8'h00, 1'b1, 8'hFE);
    compares++;
    if (got() !== want() || tsr !== 8'h02) begin
      fails++;
      $display("FAIL w0c_clear got=%h want=%h", got(), want());
    end
    cyc(8'hFF, 8'h00, 1'b1, 8'hFF);
    compares++;
    if (got() !== want() || tsr !== 8'h02) begin
      fails++;
      $display("FAIL w0c_write1 got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_set_wins();
    cyc(8'hFF, 8'h10, 1'b1, 8'h00);
    cyc(8'hFF, 8'h10, 1'b0, 8'hFF);
    cyc(8'h00, 8'h10, 1'b1, 8'hFE);
    compares++;
    if (got() !== want() || tsr !== 8'h01) begin
      fails++;
      $display("FAIL set_wins got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_irq();
    irq_mask = 2'b01;
    cyc(8'hFF, 8'h10, 1'b1, 8'h00);
    cyc(8'h00, 8'h10, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h01, 8'h10, 1'b0, 8'hFF);
      compares++;
      if (got() !== want()) begin
        fails++;
        $display("FAIL irq_hold step%0d got=%h want=%h", i, got(), want());
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(8'h01, 8'h10, 1'b1, 8'hFE);
      compares++;
      if (got() !== want()) begin
        fails++;
        $display("FAIL irq_clear step%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] c, t, wd;
    logic       w, dn;
    c  = 8'hFC;
    dn = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) dn = ~dn;
      t = 8'h00;
      t[4] = ($urandom_range(0, 3) != 0);
      t[3] = dn;
      t[7] = ($urandom_range(0, 9) == 0);
      if (t[7])
        c = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
      else if (t[4])
        c = dn ? c - 8'd1 : c + 8'd1;
      if ($urandom_range(0, 31) == 0) c = 8'(($urandom_range(0, 1) * 255));
      w  = ($urandom_range(0, 4) == 0);
      wd = 8'($urandom);
      if ($urandom_range(0, 19) == 0) irq_mask = 2'($urandom);
      cyc(c, t, w, wd);
      compares++;
      if (got() !== want()) begin
        fails++;
        $display("FAIL random step%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_async_reset();
    irq_mask = 2'b11;
    cyc(8'h01, 8'h18, 1'b1, 8'h00);
    cyc(8'h00, 8'h18, 1'b0, 8'hFF);
    cyc(8'hFF, 8'h18, 1'b0, 8'hFF);
    cyc(8'hFF, 8'h10, 1'b0, 8'hFF);
    cyc(8'h00, 8'h10, 1'b0, 8'hFF);
    compares++;
    if (tsr !== 8'h03 || ovf_pulse !== 1'b1) begin
      fails++;
      $display("FAIL areset_setup tsr=%h ovf=%b want 03/1", tsr, ovf_pulse);
    end
    #2;
    preset_n = 1'b1;
    #1;
    compares++;
    if ({tsr, ovf_pulse, udf_pulse, tmr_irq} !== 11'd0) begin
      fails++;
      $display("FAIL areset_async got=%h want=000", got());
    end
    model_reset();
    @(negedge pclk);
    preset_n = 1'b0;
    cyc(8'h01, 8'h00, 1'b0, 8'hFF);
    compares++;
    if (got() !== want()) begin
      fails++;
      $display("FAIL areset_after got=%h want=%h", got(), want());
    end
  endtask

  initial begin
    test_reset();
    test_up_ovf();
    test_down_udf();
    test_load_suppress();
    test_w0c();
    test_set_wins();
    test_irq();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
